// File: rtl/ram_march_bist.sv
// ram_march_bist
// ---------------------------------------------------------------------------
// March BIST initiator for a simple dual-port RAM with a one-cycle registered
// read port. After a start pulse it runs four march elements over addresses
// 0..DEPTH-1:
//   W_ASC   : up   -> write P
//   RW_ASC  : up   -> read (expect P),  write ~P
//   RW_DESC : down -> read (expect ~P), write P
//   R_ASC   : up   -> read (expect P)
// A single DRAIN cycle then lets the last read return before DONE.
// Every read is checked one cycle after it is issued. Mismatches are counted
// with saturation, and the first failure is captured.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse, accepted in IDLE or DONE
//   busy                : test in progress (W_ASC .. DRAIN)
//   done, pass          : test finished; pass = no mismatches
//   err_cnt             : mismatch count, saturates at 255
//   fail_addr/exp/got   : details of the first mismatch
//   write_en/addr/data  : RAM write port (registered)
//   read_en/addr        : RAM read port (registered)
//   read_data           : RAM read data, valid the cycle after read_en
// ---------------------------------------------------------------------------
module ram_march_bist #(
    parameter int unsigned          ADDR_W  = 8,
    parameter int unsigned          DATA_W  = 4,
    parameter int unsigned          DEPTH   = 256,
    parameter logic [DATA_W-1:0]    PATTERN = 4'b0101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_ASC   = 3'd1;
    localparam logic [2:0] S_RW_ASC  = 3'd2;
    localparam logic [2:0] S_RW_DESC = 3'd3;
    localparam logic [2:0] S_R_ASC   = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] PAT_N     = ~PATTERN;

    // Sequencer state
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Registered RAM-side outputs
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              read_en_q, read_en_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic [DATA_W-1:0] rexp_q, rexp_d;     // expected data for the read in flight

    // Compare stage: aligned with read_data
    logic              chk_vld_q, chk_vld_d;
    logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
    logic [DATA_W-1:0] chk_exp_q, chk_exp_d;

    // Status
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;

    logic              accept;
    logic              mismatch;

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mismatch = chk_vld_q && (read_data != chk_exp_q);

    // Next state / next address
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_W_ASC;
                    addr_d  = '0;
                end
            end
            S_W_ASC: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RW_ASC;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            S_RW_ASC: begin
                // Descending element starts from the top address.
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RW_DESC;
                    addr_d  = ADDR_LAST;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            S_RW_DESC: begin
                if (addr_q == '0) begin
                    state_d = S_R_ASC;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q - ADDR_ONE;
                end
            end
            S_R_ASC: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // RAM-side outputs are derived from the next state/address. As a result
    // the registered port reflects the state/address being executed in
    // that cycle, so there is no gap cycle between march elements.
    always_comb begin
        write_en_d   = 1'b0;
        write_addr_d = '0;
        write_data_d = '0;
        read_en_d    = 1'b0;
        read_addr_d  = '0;
        rexp_d       = '0;
        case (state_d)
            S_W_ASC: begin
                write_en_d   = 1'b1;
                write_addr_d = addr_d;
                write_data_d = PATTERN;
            end
            S_RW_ASC: begin
                write_en_d   = 1'b1;
                write_addr_d = addr_d;
                write_data_d = PAT_N;
                read_en_d    = 1'b1;
                read_addr_d  = addr_d;
                rexp_d       = PATTERN;
            end
            S_RW_DESC: begin
                write_en_d   = 1'b1;
                write_addr_d = addr_d;
                write_data_d = PATTERN;
                read_en_d    = 1'b1;
                read_addr_d  = addr_d;
                rexp_d       = PAT_N;
            end
            S_R_ASC: begin
                read_en_d    = 1'b1;
                read_addr_d  = addr_d;
                rexp_d       = PATTERN;
            end
            default: ;
        endcase
    end

    // Compare pipeline and status
    always_comb begin
        chk_vld_d   = read_en_q;
        chk_addr_d  = read_addr_q;
        chk_exp_d   = rexp_q;

        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;

        if (accept) begin
            err_cnt_d   = '0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
        end else if (mismatch) begin
            // Only the first failure is captured.
            if (err_cnt_q == 8'd0) begin
                fail_addr_d = chk_addr_q;
                fail_exp_d  = chk_exp_q;
                fail_got_d  = read_data;
            end
            if (err_cnt_q != 8'hFF)
                err_cnt_d = err_cnt_q + 8'd1;
        end

        busy_d = (state_d == S_W_ASC)   || (state_d == S_RW_ASC) ||
                 (state_d == S_RW_DESC) || (state_d == S_R_ASC)  ||
                 (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        // The final compare happens in DRAIN, so err_cnt_d is final here.
        pass_d = (state_d == S_DONE) && (err_cnt_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            read_en_q    <= 1'b0;
            read_addr_q  <= '0;
            rexp_q       <= '0;
            chk_vld_q    <= 1'b0;
            chk_addr_q   <= '0;
            chk_exp_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            read_en_q    <= read_en_d;
            read_addr_q  <= read_addr_d;
            rexp_q       <= rexp_d;
            chk_vld_q    <= chk_vld_d;
            chk_addr_q   <= chk_addr_d;
            chk_exp_q    <= chk_exp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_got_q   <= fail_got_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_addr  = fail_addr_q;
    assign fail_exp   = fail_exp_q;
    assign fail_got   = fail_got_q;
    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign read_en    = read_en_q;
    assign read_addr  = read_addr_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: a DEPTH=256 instance on a behavioural
// RAM with selectable faults, plus a DEPTH=4 instance for sequence checks.
module tb_ram_march_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DEPTH=256 instance ----------------
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [7:0] fail_addr, write_addr, read_addr;
    logic [3:0] fail_exp, fail_got, write_data, read_data, ram_q;
    logic       write_en, read_en;
    int         fault = 0;   // 0 none, 1 bit0 of 0x25 stuck-at-1, 2 read_data=0

    logic [3:0] mem [256];
    always @(posedge clk) begin
        if (write_en) mem[write_addr] <= write_data;
        if (read_en)
            ram_q <= (fault == 1 && read_addr == 8'h25) ? (mem[read_addr] | 4'b0001)
                                                        : mem[read_addr];
    end
    assign read_data = (fault == 2) ? 4'b0000 : ram_q;

    ram_march_bist #(.ADDR_W(8), .DATA_W(4), .DEPTH(256), .PATTERN(4'b0101)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data)
    );

    // ---------------- DEPTH=4 instance ----------------
    logic       start4 = 1'b0;
    logic       busy4, done4, pass4;
    logic [7:0] err4, fa4, wa4, ra4;
    logic [3:0] fe4, fg4, wd4, rd4;
    logic       we4, re4;
    logic [3:0] mem4 [4];
    always @(posedge clk) begin
        if (we4) mem4[wa4[1:0]] <= wd4;
        if (re4) rd4 <= mem4[ra4[1:0]];
    end

    ram_march_bist #(.ADDR_W(8), .DATA_W(4), .DEPTH(4), .PATTERN(4'b0101)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt(err4), .fail_addr(fa4), .fail_exp(fe4), .fail_got(fg4),
        .write_en(we4), .write_addr(wa4), .write_data(wd4),
        .read_en(re4), .read_addr(ra4), .read_data(rd4)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start; returns at #1 after the accepting edge.
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Run until done. Optionally re-pulse start at busy cycle 'inject'.
    task automatic run(input int inject, output int bc, output int wc, output int rc,
                       output bit timeout);
        bc = 0; wc = 0; rc = 0; timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) bc++;
            if (write_en) wc++;
            if (read_en) rc++;
            start = (bc == inject);
            step(1);
        end
        start = 1'b0;
    endtask

    int bc, wc, rc;
    bit to;
    logic [47:0] wseq;
    logic [15:0] rseq;

    initial begin
        // ---- reset state ----
        step(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_fail", {fail_addr, fail_exp, fail_got}, 0);
        check("rst_ram", {write_en, write_addr, write_data, read_en, read_addr}, 0);
        rst = 1'b0;
        step(2);
        check("idle_busy", busy, 0);

        // ---- fault-free full test ----
        pulse_start();
        run(-1, bc, wc, rc, to);
        check("t1_timeout", to, 0);
        check("t1_busy_cycles", bc, 1025);
        check("t1_writes", wc, 768);
        check("t1_reads", rc, 768);
        check("t1_done_pass", {done, pass, busy}, 3'b110);
        check("t1_err", err_cnt, 0);
        step(3);
        check("t1_done_held", {done, pass, busy}, 3'b110);

        // ---- stuck-at-1 on bit0 of 0x25, started from DONE ----
        fault = 1;
        pulse_start();
        check("t2_done_cleared", done, 0);
        run(-1, bc, wc, rc, to);
        check("t2_timeout", to, 0);
        check("t2_err", err_cnt, 1);
        check("t2_fail", {fail_addr, fail_exp, fail_got}, {8'h25, 4'b1010, 4'b1011});
        check("t2_pass", {done, pass}, 2'b10);

        // ---- read_data stuck at zero: saturation ----
        fault = 2;
        pulse_start();
        check("t3_err_cleared", err_cnt, 0);
        run(-1, bc, wc, rc, to);
        check("t3_timeout", to, 0);
        check("t3_err_sat", err_cnt, 255);
        check("t3_fail", {fail_addr, fail_exp, fail_got}, {8'h00, 4'b0101, 4'b0000});
        check("t3_pass", pass, 0);

        // ---- start pulsed during RW_ASC is ignored ----
        fault = 0;
        pulse_start();
        run(300, bc, wc, rc, to);
        check("t4_timeout", to, 0);
        check("t4_busy_cycles", bc, 1025);
        check("t4_pass", {done, pass, err_cnt}, {2'b11, 8'd0});

        // ---- reset during RW_DESC, then clean rerun ----
        pulse_start();
        step(600);
        check("t5_in_desc", {busy, write_en, read_en}, 3'b111);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_rst_status", {busy, done, pass, err_cnt}, 0);
        check("t5_rst_ram", {write_en, write_addr, write_data, read_en, read_addr}, 0);
        step(3);
        check("t5_idle", {busy, done, write_en}, 0);
        pulse_start();
        run(-1, bc, wc, rc, to);
        check("t5_timeout", to, 0);
        check("t5_rerun", {bc, 6'(0), done, pass}, {32'd1025, 6'(0), 2'b11});

        // ---- DEPTH=4 address sequence ----
        wseq = '0; rseq = '0; bc = 0; wc = 0; rc = 0; to = 1'b1;
        start4 = 1'b1;
        step(1);
        start4 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done4) begin
                to = 1'b0;
                break;
            end
            if (busy4) bc++;
            if (we4) begin
                wc++;
                wseq = {wseq[43:0], wa4[3:0]};
            end
            if (re4) rc++;
            if (re4 && !we4) rseq = {rseq[11:0], ra4[3:0]};
            step(1);
        end
        check("d4_timeout", to, 0);
        check("d4_busy_cycles", bc, 17);
        check("d4_counts", {wc[7:0], rc[7:0]}, {8'd12, 8'd12});
        check("d4_wseq", wseq, 48'h0123_0123_3210);
        check("d4_rseq", rseq, 16'h0123);
        check("d4_pass", {done4, pass4, err4}, {2'b11, 8'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
Built-in self-test initiator for the team's simple dual-port RAM (4-bit data, 8-bit address, registered read port). On a start pulse it runs a fixed four-element march sequence over the RAM's write and read ports. It compares every read against the expected value, counts mismatches and captures the first failure. It sits beside the RAM and drives its write/read ports during test; functional logic is muxed out while busy is high.

Parameters:
ADDR_W, 8, address width; matches RAM write_addr/read_addr.
DATA_W, 4, data width; matches RAM write_data/read_data.
DEPTH, 256, number of addresses tested (0..DEPTH-1); 2 <= DEPTH <= 2**ADDR_W.
PATTERN, 4'b0101, background pattern P; inverse ~P used in the march.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; begins a test when idle.
busy  out  1  high from the cycle after an accepted start through the DRAIN state.
done  out  1  high after a test completes; held until the next accepted start or rst.
pass  out  1  valid when done=1; 1 iff err_cnt==0.
err_cnt  out  8  mismatch count, saturating at 255.
fail_addr  out  ADDR_W  address of the first mismatch.
fail_exp  out  DATA_W  expected data at the first mismatch.
fail_got  out  DATA_W  read data at the first mismatch.
write_en  out  1  to RAM write_en.
write_addr  out  ADDR_W  to RAM write_addr.
write_data  out  DATA_W  to RAM write_data.
read_en  out  1  to RAM read_en.
read_addr  out  ADDR_W  to RAM read_addr.
read_data  in  DATA_W  from RAM; valid the cycle after read_en.

Behaviour:
- Reset: state=IDLE; busy, done, pass, err_cnt, fail_* and all RAM-side outputs are 0.
- A reset mid-test aborts at the next edge: no further writes, nothing retained.
- RAM-side outputs are registered, one state per cycle, one address per cycle.
- IDLE: start=1 -> W_ASC with addr=0, err_cnt cleared, fail_* cleared, done=0. Start is ignored in every other state except DONE.
- W_ASC: write P at addr 0..DEPTH-1 ascending.
- RW_ASC: at each addr 0..DEPTH-1 ascending, in the same cycle read (expect P) and write ~P. The RAM returns the pre-write value for a same-cycle, same-address read.
- RW_DESC: addr DEPTH-1..0 descending; read (expect ~P) and write P.
- R_ASC: addr 0..DEPTH-1 ascending; read only (expect P); write_en=0.
- DRAIN: one cycle with no RAM access; compares the last read.
- DONE: done=1, busy=0; start=1 -> new test, identical to the IDLE transition.
- Each march state lasts exactly DEPTH cycles, with no gap cycles between states.
- Total busy duration is 4*DEPTH+1 cycles; done rises on the cycle after DRAIN.
- Compare pipeline:
  - A read issued in cycle t registers the expected value and address alongside it.
  - In cycle t+1, read_data is compared against the registered expected value.
  - err_cnt and the fail_* registers update at the end of cycle t+1.
- First-failure capture: fail_* load only when err_cnt==0 and a mismatch occurs. They hold afterwards regardless of later mismatches.
- err_cnt increments by 1 per mismatching read and saturates at 255 (no wrap).
- Address counter wrap: ascending states stop at DEPTH-1 and descending states stop at 0. No address outside 0..DEPTH-1 is ever driven.
- RAM read latency is fixed at 1; no back-pressure exists.

Test Plan:
- Fault-free RAM model, DEPTH=256, pulse start -> busy high for exactly 1025 cycles; then done=1, pass=1, err_cnt=0; 768 reads and 768 writes in total.
- RAM model with bit0 of addr 0x25 stuck-at-1 -> err_cnt=1, fail_addr=0x25, fail_exp=4'b1010, fail_got=4'b1011, pass=0.
- read_data forced to 4'b0000 -> err_cnt saturates at 255 (768 mismatches); fail_addr=0x00, fail_exp=4'b0101, fail_got=4'b0000.
- start pulsed again during RW_ASC -> ignored; completion timing is unchanged (1025 busy cycles).
- rst asserted for one cycle during RW_DESC -> next cycle all outputs are 0 and write_en=0; a subsequent start runs a full clean test to pass=1.
- DEPTH=4 -> write_addr sequence 0,1,2,3 | 0,1,2,3 | 3,2,1,0, then read-only 0,1,2,3; busy lasts 17 cycles.
